duck_flight_ctrl: RTL and testbench

- Generates the duck's on-screen position and animation state for the hunt.
- Sits next to the game-logic controller:
  - feeds it duck_xpos/duck_ypos for hit testing;
  - consumes its hunt_start and duck_killed.
- Runs a fly → hit-hover → fall → respawn sequence with LFSR-randomised spawn and turns.
- Outputs drive the duck sprite renderer. Timing assumes a 1024x768 display on a 65 MHz clock (65_000 cycles/ms).

---
 rtl/duck_pkg.sv | 24 ++
 rtl/duck_lfsr16.sv | 29 ++
 rtl/duck_flight_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_duck_flight_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types, screen geometry and the LFSR step function for the duck flight logic.
package duck_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLYING  = 2'd1,
        HIT     = 2'd2,
        FALLING = 2'd3
    } flight_state_t;

    localparam int DUCK_W        = 96;
    localparam int DUCK_H        = 60;
    localparam int SCREEN_W      = 1024;
    localparam int SCREEN_H      = 768;
    localparam int CYCLES_PER_MS = 65_000;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/duck_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock from its seed.
import duck_pkg::*;

module duck_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/duck_flight_ctrl.sv
// Duck position/animation sequencer: fly, hover after a hit, fall, then wait for the next launch.
import duck_pkg::*;

module duck_flight_ctrl #(
    parameter int          TICK_CYCLES = 650_000,
    parameter int          X_MAX       = 928,
    parameter int          GROUND_Y    = 576,
    parameter int          SPEED       = 4,
    parameter int          FALL_SPEED  = 8,
    parameter int          HOVER_TICKS = 50,
    parameter int          TURN_TICKS  = 64,
    parameter int          ANIM_TICKS  = 8,
    parameter bit          RANDOM_EN   = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          game_enable,
    input  logic          hunt_start,
    input  logic          duck_killed,
    output logic [11:0]   duck_xpos,
    output logic [11:0]   duck_ypos,
    output logic          duck_dir_left,
    output logic          duck_wing_frame,
    output logic          duck_hit,
    output logic          duck_falling,
    output logic          duck_visible,
    output flight_state_t dbg_state
);

    localparam int             TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [7:0]     HOVER_LAST  = 8'(HOVER_TICKS - 1);
    localparam logic [7:0]     TURN_LAST   = 8'(TURN_TICKS - 1);
    localparam logic [7:0]     ANIM_LAST   = 8'(ANIM_TICKS - 1);
    localparam logic [11:0]    X_MAX_C     = 12'(X_MAX);
    localparam logic [11:0]    GROUND_C    = 12'(GROUND_Y);
    localparam logic [11:0]    SPEED_C     = 12'(SPEED);
    localparam logic [11:0]    FALL_C      = 12'(FALL_SPEED);
    localparam logic [11:0]    X_CENTER    = 12'd464;

    flight_state_t state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    turn_cnt_q, turn_cnt_d;
    logic [7:0]    anim_cnt_q, anim_cnt_d;
    logic [7:0]    hover_cnt_q, hover_cnt_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic          dir_left_q, dir_left_d;
    logic          dir_up_q, dir_up_d;
    logic          wing_q, wing_d;
    logic          hunt_prev_q, hunt_prev_d;
    logic          hit_q, hit_d;
    logic          falling_q, falling_d;
    logic          visible_q, visible_d;

    logic          tick;
    logic [11:0]   raw_x;
    logic [11:0]   spawn_x;
    logic [15:0]   lfsr;
    logic          lfsr_unused;

    duck_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:11];
    assign tick        = (tick_cnt_q == TICK_LAST);

    // Spawn column folds values past the right edge back by half the 10-bit range.
    always_comb begin
        raw_x   = {2'b00, lfsr[9:0]};
        spawn_x = (raw_x > X_MAX_C) ? (raw_x - 12'd512) : raw_x;
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        turn_cnt_d  = turn_cnt_q;
        anim_cnt_d  = anim_cnt_q;
        hover_cnt_d = hover_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_left_d  = dir_left_q;
        dir_up_d    = dir_up_q;
        wing_d      = wing_q;
        hunt_prev_d = hunt_start;

        if (!game_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hunt_start && !hunt_prev_q) begin
                        state_d  = FLYING;
                        y_d      = GROUND_C;
                        dir_up_d = 1'b1;
                        if (RANDOM_EN) begin
                            x_d        = spawn_x;
                            dir_left_d = lfsr[10];
                        end else begin
                            x_d        = X_CENTER;
                            dir_left_d = 1'b0;
                        end
                    end
                end
                FLYING: begin
                    if (duck_killed) begin
                        state_d = HIT;
                    end else if (tick && hunt_start) begin
                        if (!dir_left_q) begin
                            if (x_q + SPEED_C >= X_MAX_C) begin
                                x_d        = X_MAX_C;
                                dir_left_d = 1'b1;
                            end else begin
                                x_d = x_q + SPEED_C;
                            end
                        end else if (x_q <= SPEED_C) begin
                            x_d        = '0;
                            dir_left_d = 1'b0;
                        end else begin
                            x_d = x_q - SPEED_C;
                        end

                        if (dir_up_q) begin
                            if (y_q <= SPEED_C) begin
                                y_d      = '0;
                                dir_up_d = 1'b0;
                            end else begin
                                y_d = y_q - SPEED_C;
                            end
                        end else if (y_q + SPEED_C >= GROUND_C) begin
                            y_d      = GROUND_C;
                            dir_up_d = 1'b1;
                        end else begin
                            y_d = y_q + SPEED_C;
                        end

                        if (anim_cnt_q == ANIM_LAST) begin
                            anim_cnt_d = '0;
                            wing_d     = ~wing_q;
                        end else begin
                            anim_cnt_d = anim_cnt_q + 8'd1;
                        end

                        // Random turn is applied on top of any bounce decided this tick.
                        if (turn_cnt_q == TURN_LAST) begin
                            turn_cnt_d = '0;
                            if (RANDOM_EN) begin
                                dir_up_d = dir_up_d ^ lfsr[0];
                            end
                        end else begin
                            turn_cnt_d = turn_cnt_q + 8'd1;
                        end
                    end
                end
                HIT: begin
                    if (tick) begin
                        if (hover_cnt_q == HOVER_LAST) begin
                            state_d = FALLING;
                        end else begin
                            hover_cnt_d = hover_cnt_q + 8'd1;
                        end
                    end
                end
                FALLING: begin
                    if (tick) begin
                        if (y_q + FALL_C >= GROUND_C) begin
                            y_d     = GROUND_C;
                            state_d = IDLE;
                        end else begin
                            y_d = y_q + FALL_C;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) begin
            turn_cnt_d  = '0;
            anim_cnt_d  = '0;
            hover_cnt_d = '0;
        end

        hit_d     = (state_d == HIT);
        falling_d = (state_d == FALLING);
        visible_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            turn_cnt_q  <= '0;
            anim_cnt_q  <= '0;
            hover_cnt_q <= '0;
            x_q         <= X_CENTER;
            y_q         <= GROUND_C;
            dir_left_q  <= 1'b0;
            dir_up_q    <= 1'b1;
            wing_q      <= 1'b0;
            hunt_prev_q <= 1'b0;
            hit_q       <= 1'b0;
            falling_q   <= 1'b0;
            visible_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            anim_cnt_q  <= anim_cnt_d;
            hover_cnt_q <= hover_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_left_q  <= dir_left_d;
            dir_up_q    <= dir_up_d;
            wing_q      <= wing_d;
            hunt_prev_q <= hunt_prev_d;
            hit_q       <= hit_d;
            falling_q   <= falling_d;
            visible_q   <= visible_d;
        end
    end

    assign duck_xpos       = x_q;
    assign duck_ypos       = y_q;
    assign duck_dir_left   = dir_left_q;
    assign duck_wing_frame = wing_q;
    assign duck_hit        = hit_q;
    assign duck_falling    = falling_q;
    assign duck_visible    = visible_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed bench for duck_flight_ctrl: deterministic flight/kill/fall sequence plus randomised spawns.
module tb_duck_flight_ctrl;

    localparam int TICK = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic        ge, hs, dk;
    logic [11:0] x, y;
    logic        dl, wf, hit, fall, vis;
    logic [1:0]  st;

    logic        r_ge, r_hs, r_dk;
    logic [11:0] r_x, r_y;
    logic        r_dl, r_wf, r_hit, r_fall, r_vis;
    logic [1:0]  r_st;

    int n_checks = 0;
    int n_errors = 0;
    int ticks;
    int tcnt;
    logic [15:0] lm;

    always #5 clk = ~clk;

    duck_flight_ctrl #(.TICK_CYCLES(TICK), .RANDOM_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .game_enable(ge), .hunt_start(hs), .duck_killed(dk),
        .duck_xpos(x), .duck_ypos(y), .duck_dir_left(dl), .duck_wing_frame(wf),
        .duck_hit(hit), .duck_falling(fall), .duck_visible(vis), .dbg_state(st)
    );

    duck_flight_ctrl #(.TICK_CYCLES(TICK), .RANDOM_EN(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .game_enable(r_ge), .hunt_start(r_hs), .duck_killed(r_dk),
        .duck_xpos(r_x), .duck_ypos(r_y), .duck_dir_left(r_dl), .duck_wing_frame(r_wf),
        .duck_hit(r_hit), .duck_falling(r_fall), .duck_visible(r_vis), .dbg_state(r_st)
    );

    // Tick reference: wraps on the same edge as the design's free-running counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= 0;
            ticks <= 0;
            lm    <= 16'hACE1;
        end else begin
            if (tcnt == TICK - 1) begin
                tcnt  <= 0;
                ticks <= ticks + 1;
            end else begin
                tcnt <= tcnt + 1;
            end
            lm <= {1'b0, lm[15:1]} ^ (lm[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = ticks + n;
        budget = n * TICK + 8;
        while (ticks < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (ticks < target) chk("tick_budget", ticks, target);
    endtask

    task automatic launch();
        hs = 1'b0;
        cyc(1);
        hs = 1'b1;
        cyc(1);
    endtask

    task automatic chk_pos(input string tag, input logic [11:0] xe, input logic [11:0] ye);
        chk({tag, "_x"}, x, xe);
        chk({tag, "_y"}, y, ye);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] xr;
        ge = 1'b0; hs = 1'b0; dk = 1'b0;
        r_ge = 1'b0; r_hs = 1'b0; r_dk = 1'b0;
        rst_n = 1'b0;
        cyc(2);

        chk_pos("rst", 12'd464, 12'd576);
        chk("rst_vis", vis, 0);
        chk("rst_hit", hit, 0);
        chk("rst_fall", fall, 0);
        chk("rst_dl", dl, 0);
        chk("rst_wf", wf, 0);
        chk("rst_st", st, 0);
        rst_n = 1'b1;
        ge = 1'b1;
        cyc(1);

        dk = 1'b1; cyc(1); dk = 1'b0; cyc(1);
        chk("idle_kill_st", st, 0);
        chk("idle_kill_hit", hit, 0);

        launch();
        chk("launch_st", st, 1);
        chk("launch_vis", vis, 1);
        chk("launch_dl", dl, 0);
        chk_pos("launch", 12'd464, 12'd576);
        wait_ticks(1);   chk_pos("t1", 12'd468, 12'd572);
        wait_ticks(6);   chk("t7_wf", wf, 0);
        wait_ticks(1);   chk("t8_wf", wf, 1); chk("t8_x", x, 496);
        wait_ticks(107); chk("t115_x", x, 924); chk("t115_dl", dl, 0);
        wait_ticks(1);   chk_pos("t116", 12'd928, 12'd112); chk("t116_dl", dl, 1);
        wait_ticks(1);   chk_pos("t117", 12'd924, 12'd108);
        wait_ticks(27);  chk_pos("t144", 12'd816, 12'd0);
        wait_ticks(1);   chk_pos("t145", 12'd812, 12'd4); chk("t145_wf", wf, 0);

        hs = 1'b0;
        wait_ticks(20);  chk_pos("freeze", 12'd812, 12'd4); chk("freeze_st", st, 1);
        hs = 1'b1;
        wait_ticks(1);   chk_pos("resume", 12'd808, 12'd8);

        ge = 1'b0; cyc(1);
        chk("ge_off_st", st, 0); chk("ge_off_vis", vis, 0); chk_pos("ge_off", 12'd808, 12'd8);
        ge = 1'b1;

        launch();
        chk_pos("relaunch", 12'd464, 12'd576); chk("relaunch_dl", dl, 0);
        wait_ticks(10);  chk_pos("t10", 12'd504, 12'd536);
        dk = 1'b1; cyc(1); dk = 1'b0;
        chk("kill_hit", hit, 1); chk("kill_st", st, 2); chk_pos("kill", 12'd504, 12'd536);
        wait_ticks(49);  chk("hover49_hit", hit, 1); chk("hover49_fall", fall, 0); chk_pos("hover49", 12'd504, 12'd536);
        wait_ticks(1);   chk("hover50_fall", fall, 1); chk("hover50_hit", hit, 0); chk("hover50_y", y, 536);
        wait_ticks(1);   chk("fall1_y", y, 544);
        wait_ticks(3);   chk("fall4_y", y, 568); chk("fall4_vis", vis, 1);
        wait_ticks(1);   chk_pos("land", 12'd504, 12'd576);
        chk("land_st", st, 0); chk("land_vis", vis, 0); chk("land_fall", fall, 0);

        launch();
        wait_ticks(20);  chk_pos("t20", 12'd544, 12'd496);
        dk = 1'b1; cyc(1); dk = 1'b0;
        wait_ticks(50);  chk("mf_fall", fall, 1);
        wait_ticks(1);   chk("mf_y", y, 504);
        ge = 1'b0; cyc(1);
        chk("mf_off_st", st, 0); chk("mf_off_fall", fall, 0); chk("mf_off_y", y, 504);
        ge = 1'b1;

        launch();
        wait_ticks(3);   chk("ar_pre_x", x, 476);
        #2 rst_n = 1'b0;
        hs = 1'b0;
        #1;
        chk_pos("areset", 12'd464, 12'd576);
        chk("areset_vis", vis, 0);
        chk("areset_st", st, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        r_ge = 1'b1;
        for (int i = 0; i < 100; i++) begin
            xr = {2'b00, lm[9:0]};
            if (xr > 12'd928) xr = xr - 12'd512;
            chk("rnd_dl", r_dl, r_dl);
            n_checks--;
            begin
                logic exp_dl;
                exp_dl = lm[10];
                r_hs = 1'b1;
                cyc(1);
                chk("rnd_st", r_st, 1);
                chk("rnd_x", r_x, xr);
                chk("rnd_dl", r_dl, exp_dl);
                chk("rnd_xmax", (r_x <= 12'd928), 1);
            end
            r_ge = 1'b0; r_hs = 1'b0;
            cyc(1);
            r_ge = 1'b1;
            cyc(1 + $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
